// File: rtl/song_sequencer_pkg.sv
// rtl/song_sequencer_pkg.sv - shared state encoding and default constants for the song sequencer
//
// Contents:
//   seq_state_e             sequencer FSM state encoding
//   DEF_*                   default address, width, tempo and latency constants
//   DEF_AMP                 sample magnitude driven to the audio mixer
package song_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_PLAY  = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_ADDR_W            = 10;
  localparam int unsigned DEF_NOTE_W            = 20;
  localparam int unsigned DEF_LAST_ADDR         = 252;
  localparam int unsigned DEF_TEMPO_SWITCH_ADDR = 197;
  localparam int unsigned DEF_TEMPO_SLOW        = 9200000;
  localparam int unsigned DEF_TEMPO_FAST        = 7800000;
  localparam int unsigned DEF_CNT_W             = 27;
  localparam int unsigned DEF_ROM_LAT           = 2;

  localparam logic signed [31:0] DEF_AMP = 32'sd1000000000;

endpackage

// File: rtl/song_sequencer_square_tone_gen.sv
// rtl/song_sequencer_square_tone_gen.sv - square-wave tone generator and mixer sample select
//
// Ports:
//   clk          in   system clock
//   resetn       in   synchronous active-low reset
//   clear        in   synchronous clear of the half-period counter and tone
//   active       in   sequencer is playing and not paused
//   half_period  in   current note half-period in clock cycles (0 = rest)
//   tone_valid   out  note sounding
//   tone_out     out  square wave
//   sample       out  signed +AMP / -AMP while sounding, else 0
module square_tone_gen import song_sequencer_pkg::*; #(
  parameter int unsigned       NOTE_W = DEF_NOTE_W,
  parameter logic signed [31:0] AMP   = DEF_AMP
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clear,
  input  logic                active,
  input  logic [NOTE_W-1:0]   half_period,
  output logic                tone_valid,
  output logic                tone_out,
  output logic signed [31:0]  sample
);

  // Negative level is a folded constant, so the sample path is a pure mux.
  localparam logic signed [31:0] AMP_NEG = -AMP;

  logic [NOTE_W-1:0] cnt_q, cnt_d;
  logic              tone_q, tone_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  // A zero half-period is a rest: never sounding, so the tone never toggles.
  assign tone_valid = active && (half_period != '0);

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (clear) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (tone_valid) begin
      if (cnt_q == half_period - NOTE_W'(1)) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d = cnt_q + NOTE_W'(1);
      end
    end
  end

  assign tone_out = tone_q;

  always_comb begin
    sample = '0;
    if (tone_valid) begin
      sample = tone_q ? AMP : AMP_NEG;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - note ROM sequencer with tempo control, pause, restart and loop
//
// Ports:
//   CLOCK_50     in   system clock
//   resetn       in   synchronous active-low reset
//   play         in   level: 1 = run, 0 = pause
//   restart      in   one-cycle pulse: return to address 0
//   loop_en      in   1 = wrap after LAST_ADDR, 0 = stop in DONE
//   rom_addr     out  registered note ROM address
//   rom_q        in   note ROM data (half-period), ROM_LAT cycles behind rom_addr
//   half_period  out  latched current note
//   note_strobe  out  one-cycle pulse after a note is latched
//   tone_valid   out  note sounding
//   tone_out     out  square wave
//   sample       out  signed 32-bit mixer sample
//   song_done    out  high while in DONE
module song_sequencer import song_sequencer_pkg::*; #(
  parameter int unsigned        ADDR_W            = DEF_ADDR_W,
  parameter int unsigned        NOTE_W            = DEF_NOTE_W,
  parameter int unsigned        LAST_ADDR         = DEF_LAST_ADDR,
  parameter int unsigned        TEMPO_SWITCH_ADDR = DEF_TEMPO_SWITCH_ADDR,
  parameter int unsigned        TEMPO_SLOW        = DEF_TEMPO_SLOW,
  parameter int unsigned        TEMPO_FAST        = DEF_TEMPO_FAST,
  parameter int unsigned        CNT_W             = DEF_CNT_W,
  parameter int unsigned        ROM_LAT           = DEF_ROM_LAT,
  parameter logic signed [31:0] AMP               = DEF_AMP
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                play,
  input  logic                restart,
  input  logic                loop_en,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [NOTE_W-1:0]   rom_q,
  output logic [NOTE_W-1:0]   half_period,
  output logic                note_strobe,
  output logic                tone_valid,
  output logic                tone_out,
  output logic signed [31:0]  sample,
  output logic                song_done
);

  localparam int WAIT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  localparam logic [CNT_W-1:0]  SLOW_LAST   = CNT_W'(TEMPO_SLOW - 1);
  localparam logic [CNT_W-1:0]  FAST_LAST   = CNT_W'(TEMPO_FAST - 1);
  localparam logic [ADDR_W-1:0] LAST_A      = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] SWITCH_A    = ADDR_W'(TEMPO_SWITCH_ADDR);
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(ROM_LAT - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NOTE_W-1:0] hp_q, hp_d;
  logic [CNT_W-1:0]  dur_q, dur_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              strobe_q, strobe_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  dur_limit;
  logic              dur_last;
  logic              note_end;
  logic              at_last;
  logic              fetch_done;
  logic              tone_clear;
  logic              tone_active;

  // State register

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      hp_q     <= '0;
      dur_q    <= '0;
      wait_q   <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      hp_q     <= hp_d;
      dur_q    <= dur_d;
      wait_q   <= wait_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  // The tempo is chosen by the address of the note being played.
  assign dur_limit  = (addr_q <= SWITCH_A) ? SLOW_LAST : FAST_LAST;
  assign dur_last   = (dur_q == dur_limit);
  assign note_end   = (state_q == ST_PLAY) && play && dur_last;
  assign at_last    = (addr_q == LAST_A);
  assign fetch_done = (wait_q == WAIT_LAST);

  // Next-state logic

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (play) state_d = ST_FETCH;
      ST_FETCH: if (fetch_done) state_d = ST_LATCH;
      ST_LATCH: state_d = ST_PLAY;
      ST_PLAY:  if (note_end) state_d = (at_last && !loop_en) ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    // restart outranks both a note end and the DONE hold.
    if (restart) begin
      state_d = play ? ST_FETCH : ST_IDLE;
    end
  end

  // Datapath and registered outputs

  always_comb begin
    addr_d     = addr_q;
    hp_d       = hp_q;
    dur_d      = dur_q;
    wait_d     = wait_q;
    strobe_d   = 1'b0;
    done_d     = done_q;
    tone_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wait_d = '0;
      end
      ST_FETCH: begin
        if (!fetch_done) wait_d = wait_q + WAIT_W'(1);
      end
      ST_LATCH: begin
        hp_d       = rom_q;
        strobe_d   = 1'b1;
        dur_d      = '0;
        tone_clear = 1'b1;
      end
      ST_PLAY: begin
        // Pause (play=0) leaves the duration count untouched.
        if (play) begin
          if (dur_last) begin
            wait_d = '0;
            if (!at_last)    addr_d = addr_q + ADDR_W'(1);
            else if (loop_en) addr_d = '0;
            else              done_d = 1'b1;
          end else begin
            dur_d = dur_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
    if (restart) begin
      addr_d     = '0;
      hp_d       = '0;
      dur_d      = '0;
      wait_d     = '0;
      strobe_d   = 1'b0;
      done_d     = 1'b0;
      tone_clear = 1'b1;
    end
  end

  assign tone_active = (state_q == ST_PLAY) && play;

  assign rom_addr    = addr_q;
  assign half_period = hp_q;
  assign note_strobe = strobe_q;
  assign song_done   = done_q;

  square_tone_gen #(
    .NOTE_W (NOTE_W),
    .AMP    (AMP)
  ) u_tone (
    .clk         (CLOCK_50),
    .resetn      (resetn),
    .clear       (tone_clear),
    .active      (tone_active),
    .half_period (hp_q),
    .tone_valid  (tone_valid),
    .tone_out    (tone_out),
    .sample      (sample)
  );

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - directed self-checking bench for song_sequencer
module tb_song_sequencer;

  localparam logic signed [31:0] P_AMP = 32'sd1000000000;
  localparam logic signed [31:0] N_AMP = -32'sd1000000000;

  logic               CLOCK_50 = 1'b0;
  logic               resetn   = 1'b0;
  logic               play     = 1'b0;
  logic               restart  = 1'b0;
  logic               loop_en  = 1'b0;
  logic [9:0]         rom_addr;
  logic [19:0]        rom_q;
  logic [19:0]        half_period;
  logic               note_strobe;
  logic               tone_valid;
  logic               tone_out;
  logic signed [31:0] sample;
  logic               song_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] rom_mem [0:3];
  logic [19:0] rom_d1;

  initial begin
    rom_mem[0] = 20'd4;
    rom_mem[1] = 20'd0;
    rom_mem[2] = 20'd2;
    rom_mem[3] = 20'd3;
    rom_d1     = '0;
    rom_q      = '0;
  end

  // Two-cycle ROM: address register stage then output register stage.
  always @(posedge CLOCK_50) begin
    rom_d1 <= rom_mem[rom_addr[1:0]];
    rom_q  <= rom_d1;
  end

  always #5 CLOCK_50 = ~CLOCK_50;

  song_sequencer #(
    .ADDR_W            (10),
    .NOTE_W            (20),
    .LAST_ADDR         (3),
    .TEMPO_SWITCH_ADDR (1),
    .TEMPO_SLOW        (10),
    .TEMPO_FAST        (5),
    .CNT_W             (27),
    .ROM_LAT           (2),
    .AMP               (P_AMP)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .play        (play),
    .restart     (restart),
    .loop_en     (loop_en),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .half_period (half_period),
    .note_strobe (note_strobe),
    .tone_valid  (tone_valid),
    .tone_out    (tone_out),
    .sample      (sample),
    .song_done   (song_done)
  );

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    resetn  = 1'b0;
    play    = 1'b0;
    restart = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  // Leaves the bench in cycle 0, the first cycle after leaving IDLE.
  task automatic start_play();
    play = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (rom_addr !== 10'd0) begin n_fail++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
    n_checks++; if (half_period !== 20'd0) begin n_fail++; $display("FAIL reset_half_period got %0d want 0", half_period); end
    n_checks++; if (note_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_note_strobe got %b want 0", note_strobe); end
    n_checks++; if (song_done !== 1'b0) begin n_fail++; $display("FAIL reset_song_done got %b want 0", song_done); end
    n_checks++; if (tone_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tone_valid got %b want 0", tone_valid); end
    n_checks++; if (tone_out !== 1'b0) begin n_fail++; $display("FAIL reset_tone_out got %b want 0", tone_out); end
    n_checks++; if (sample !== 32'sd0) begin n_fail++; $display("FAIL reset_sample got %0d want 0", sample); end
  endtask

  task automatic test_play_once();
    int          sc[$];
    logic [19:0] sh[$];
    int          exp_c [4];
    logic [19:0] exp_h [4];
    exp_c = '{3, 16, 29, 37};
    exp_h = '{20'd4, 20'd0, 20'd2, 20'd3};
    loop_en = 1'b0;
    do_reset();
    start_play();
    for (int c = 0; c < 50; c++) begin
      if (note_strobe) begin sc.push_back(c); sh.push_back(half_period); end
      if (c == 41) begin
        n_checks++; if (song_done !== 1'b0) begin n_fail++; $display("FAIL once_done_early got %b want 0", song_done); end
      end
      if (c == 45) begin
        n_checks++; if (song_done !== 1'b1) begin n_fail++; $display("FAIL once_done got %b want 1", song_done); end
        n_checks++; if (rom_addr !== 10'd3) begin n_fail++; $display("FAIL once_addr_held got %0d want 3", rom_addr); end
      end
      if (c == 49) begin
        n_checks++; if (song_done !== 1'b1) begin n_fail++; $display("FAIL once_done_hold got %b want 1", song_done); end
      end
      step();
    end
    n_checks++; if (sc.size() !== 4) begin n_fail++; $display("FAIL once_strobe_count got %0d want 4", sc.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= sc.size() || sc[i] !== exp_c[i] || sh[i] !== exp_h[i]) begin
        n_fail++;
        if (i < sc.size()) $display("FAIL once_strobe%0d got cycle %0d hp %0d want cycle %0d hp %0d", i, sc[i], sh[i], exp_c[i], exp_h[i]);
        else $display("FAIL once_strobe%0d got none want cycle %0d hp %0d", i, exp_c[i], exp_h[i]);
      end
    end
  endtask

  task automatic test_tone();
    logic               exp_t;
    logic signed [31:0] exp_s;
    loop_en = 1'b0;
    do_reset();
    start_play();
    for (int c = 0; c < 28; c++) begin
      if (c >= 3 && c <= 12) begin
        exp_t = (((c - 3) / 4) % 2) == 1;
        exp_s = exp_t ? P_AMP : N_AMP;
        n_checks++; if (tone_valid !== 1'b1) begin n_fail++; $display("FAIL tone_valid_c%0d got %b want 1", c, tone_valid); end
        n_checks++; if (tone_out !== exp_t) begin n_fail++; $display("FAIL tone_out_c%0d got %b want %b", c, tone_out, exp_t); end
        n_checks++; if (sample !== exp_s) begin n_fail++; $display("FAIL tone_sample_c%0d got %0d want %0d", c, sample, exp_s); end
      end
      if (c >= 16 && c <= 25) begin
        n_checks++; if (tone_valid !== 1'b0) begin n_fail++; $display("FAIL rest_valid_c%0d got %b want 0", c, tone_valid); end
        n_checks++; if (sample !== 32'sd0) begin n_fail++; $display("FAIL rest_sample_c%0d got %0d want 0", c, sample); end
      end
      step();
    end
  endtask

  task automatic test_loop();
    int          sc[$];
    logic [19:0] sh[$];
    logic        done_seen;
    int          exp_c [5];
    logic [19:0] exp_h [5];
    exp_c = '{3, 16, 29, 37, 45};
    exp_h = '{20'd4, 20'd0, 20'd2, 20'd3, 20'd4};
    done_seen = 1'b0;
    loop_en = 1'b1;
    do_reset();
    start_play();
    for (int c = 0; c < 60; c++) begin
      if (note_strobe) begin sc.push_back(c); sh.push_back(half_period); end
      if (song_done) done_seen = 1'b1;
      if (c == 45) begin
        n_checks++; if (rom_addr !== 10'd0) begin n_fail++; $display("FAIL loop_wrap_addr got %0d want 0", rom_addr); end
      end
      step();
    end
    n_checks++; if (done_seen !== 1'b0) begin n_fail++; $display("FAIL loop_done_seen got %b want 0", done_seen); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= sc.size() || sc[i] !== exp_c[i] || sh[i] !== exp_h[i]) begin
        n_fail++;
        if (i < sc.size()) $display("FAIL loop_strobe%0d got cycle %0d hp %0d want cycle %0d hp %0d", i, sc[i], sh[i], exp_c[i], exp_h[i]);
        else $display("FAIL loop_strobe%0d got none want cycle %0d", i, exp_c[i]);
      end
    end
    loop_en = 1'b0;
  endtask

  task automatic test_pause();
    int          sc[$];
    logic [19:0] sh[$];
    loop_en = 1'b0;
    do_reset();
    start_play();
    for (int c = 0; c < 50; c++) begin
      if (c == 31) play = 1'b0;
      if (c == 38) play = 1'b1;
      #1;
      if (note_strobe) begin sc.push_back(c); sh.push_back(half_period); end
      if (c == 33) begin
        n_checks++; if (tone_valid !== 1'b0) begin n_fail++; $display("FAIL pause_valid got %b want 0", tone_valid); end
        n_checks++; if (sample !== 32'sd0) begin n_fail++; $display("FAIL pause_sample got %0d want 0", sample); end
      end
      if (c == 35) begin
        n_checks++; if (tone_out !== 1'b1) begin n_fail++; $display("FAIL pause_tone_frozen got %b want 1", tone_out); end
      end
      if (c == 38) begin
        n_checks++; if (sample !== P_AMP) begin n_fail++; $display("FAIL pause_resume_sample got %0d want %0d", sample, P_AMP); end
      end
      if (c == 40) begin
        n_checks++; if (tone_out !== 1'b0) begin n_fail++; $display("FAIL pause_resume_toggle got %b want 0", tone_out); end
      end
      step();
    end
    n_checks++;
    if (sc.size() < 4 || sc[3] !== 44 || sh[3] !== 20'd3) begin
      n_fail++;
      if (sc.size() >= 4) $display("FAIL pause_note_end got cycle %0d hp %0d want cycle 44 hp 3", sc[3], sh[3]);
      else $display("FAIL pause_note_end got %0d strobes want 4", sc.size());
    end
  endtask

  task automatic test_restart_note_end();
    logic [9:0] max_addr;
    max_addr = '0;
    loop_en = 1'b0;
    do_reset();
    start_play();
    for (int c = 0; c < 40; c++) begin
      if (c == 33) restart = 1'b1;
      if (c == 34) restart = 1'b0;
      #1;
      if (rom_addr > max_addr) max_addr = rom_addr;
      if (c == 34) begin
        n_checks++; if (rom_addr !== 10'd0) begin n_fail++; $display("FAIL rst_addr got %0d want 0", rom_addr); end
        n_checks++; if (half_period !== 20'd0) begin n_fail++; $display("FAIL rst_hp got %0d want 0", half_period); end
      end
      if (c >= 34 && c <= 36) begin
        n_checks++; if (note_strobe !== 1'b0) begin n_fail++; $display("FAIL rst_early_strobe_c%0d got %b want 0", c, note_strobe); end
      end
      if (c == 37) begin
        n_checks++; if (note_strobe !== 1'b1) begin n_fail++; $display("FAIL rst_strobe got %b want 1", note_strobe); end
        n_checks++; if (half_period !== 20'd4) begin n_fail++; $display("FAIL rst_strobe_hp got %0d want 4", half_period); end
      end
      step();
    end
    n_checks++; if (max_addr !== 10'd2) begin n_fail++; $display("FAIL rst_max_addr got %0d want 2", max_addr); end
  endtask

  task automatic test_restart_done();
    int sc[$];
    loop_en = 1'b0;
    do_reset();
    start_play();
    for (int c = 0; c < 46; c++) step();
    n_checks++; if (song_done !== 1'b1) begin n_fail++; $display("FAIL rdone_in_done got %b want 1", song_done); end
    play    = 1'b0;
    restart = 1'b1;
    step();
    restart = 1'b0;
    n_checks++; if (song_done !== 1'b0) begin n_fail++; $display("FAIL rdone_done_cleared got %b want 0", song_done); end
    n_checks++; if (rom_addr !== 10'd0) begin n_fail++; $display("FAIL rdone_addr got %0d want 0", rom_addr); end
    for (int c = 0; c < 4; c++) begin
      if (note_strobe) sc.push_back(100 + c);
      step();
    end
    n_checks++; if (sc.size() !== 0) begin n_fail++; $display("FAIL rdone_idle_strobe got %0d want 0", sc.size()); end
    start_play();
    for (int c = 0; c < 8; c++) begin
      if (note_strobe) begin
        sc.push_back(c);
        if (c == 3) begin
          n_checks++; if (half_period !== 20'd4) begin n_fail++; $display("FAIL rdone_hp got %0d want 4", half_period); end
        end
      end
      step();
    end
    n_checks++;
    if (sc.size() !== 1 || sc[0] !== 3) begin
      n_fail++;
      if (sc.size() > 0) $display("FAIL rdone_first_strobe got cycle %0d count %0d want cycle 3 count 1", sc[0], sc.size());
      else $display("FAIL rdone_first_strobe got none want cycle 3");
    end
  endtask

  initial begin
    test_reset();
    test_play_once();
    test_tone();
    test_loop();
    test_pause();
    test_restart_note_end();
    test_restart_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
